// File: rtl/pipe_adder_pkg.sv
// ----------------------------------------------------------------------------
// pipe_adder_pkg
// Shared constants, helpers and record types for the pipelined adder.
//   DEFAULT_WIDTH / DEFAULT_STAGES : default operand width and stage count
//   chunk_width()                  : bits resolved per pipeline stage
//   stage_rec_t                    : one stage's register contents, sized for
//                                    the default configuration
// ----------------------------------------------------------------------------
package pipe_adder_pkg;

    localparam int DEFAULT_WIDTH  = 16;
    localparam int DEFAULT_STAGES = 4;

    function automatic int chunk_width(input int width, input int stages);
        return width / stages;
    endfunction

    // lo_sum holds the sum bits already resolved; hi_a/hi_b hold the operand
    // bits not yet consumed. Only the relevant slices are meaningful at a
    // given stage.
    typedef struct packed {
        logic                     valid;
        logic                     carry;
        logic [DEFAULT_WIDTH-1:0] lo_sum;
        logic [DEFAULT_WIDTH-1:0] hi_a;
        logic [DEFAULT_WIDTH-1:0] hi_b;
    } stage_rec_t;

endpackage

// File: rtl/pipe_adder_chunk.sv
// ----------------------------------------------------------------------------
// adder_chunk
// Purely combinational CHUNK-bit adder with carry in and carry out.
//   a, b : CHUNK-bit operands
//   cin  : carry in
//   sum  : (a + b + cin) mod 2^CHUNK
//   cout : carry out of the chunk
// ----------------------------------------------------------------------------
module adder_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/pipe_adder.sv
// ----------------------------------------------------------------------------
// pipe_adder
// WIDTH-bit adder with carry-in, split over STAGES register stages. Stage k
// resolves bits [k*CHUNK +: CHUNK]; the inter-chunk carry is registered.
// Valid/ready streaming handshake; the whole pipe advances or stalls as one.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : input beat handshake
//   a, b, cin           : operands and carry in
//   out_valid/out_ready : output beat handshake
//   sum, cout           : result, driven straight from the last stage flops
// ----------------------------------------------------------------------------
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CHUNK = chunk_width(WIDTH, STAGES);

    if (WIDTH < 1 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_check
        $error("pipe_adder: STAGES must be >= 1 and divide WIDTH (>= 1)");
    end

    // The pipe moves as a unit: it may shift whenever the final slot is
    // empty or being consumed. Independent of in_valid by design.
    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    genvar gi;
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
        localparam int LO  = gi * CHUNK;   // sum bits resolved before this stage
        localparam int REM = WIDTH - LO;   // operand bits still unconsumed here

        logic [REM-1:0]      a_rem;
        logic [REM-1:0]      b_rem;
        logic                carry_in;
        logic                valid_in;
        logic [CHUNK-1:0]    s_chunk;
        logic                c_chunk;
        logic [LO+CHUNK-1:0] s_next;

        logic                v_q;
        logic                c_q;
        logic [LO+CHUNK-1:0] s_q;

        if (gi == 0) begin : g_src
            assign a_rem    = a;
            assign b_rem    = b;
            assign carry_in = cin;
            assign valid_in = in_valid;
            assign s_next   = s_chunk;
        end else begin : g_src
            assign a_rem    = g_stage[gi-1].g_ops.a_q;
            assign b_rem    = g_stage[gi-1].g_ops.b_q;
            assign carry_in = g_stage[gi-1].c_q;
            assign valid_in = g_stage[gi-1].v_q;
            // New chunk lands above the bits already resolved upstream.
            assign s_next   = {s_chunk, g_stage[gi-1].s_q};
        end

        adder_chunk #(.CHUNK(CHUNK)) u_chunk (
            .a    (a_rem[CHUNK-1:0]),
            .b    (b_rem[CHUNK-1:0]),
            .cin  (carry_in),
            .sum  (s_chunk),
            .cout (c_chunk)
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (advance) begin
                v_q <= valid_in;
                c_q <= c_chunk;
                s_q <= s_next;
            end
        end

        // Upper operand chunks travel only as far as they are still needed;
        // the last stage consumes the final chunk and stores none.
        if (gi < STAGES - 1) begin : g_ops
            localparam int NXT = REM - CHUNK;
            logic [NXT-1:0] a_q;
            logic [NXT-1:0] b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= a_rem[REM-1:CHUNK];
                    b_q <= b_rem[REM-1:CHUNK];
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].v_q;
    assign sum       = g_stage[STAGES-1].s_q;
    assign cout      = g_stage[STAGES-1].c_q;

endmodule

// File: tb/tb_pipe_adder.sv
// ----------------------------------------------------------------------------
// tb_pipe_adder
// Scoreboard bench for pipe_adder (16-bit / 4-stage) plus a 1-bit / 1-stage
// instance exercised as a half adder. Expected results come from plain
// integer addition of the operands.
// ----------------------------------------------------------------------------
module tb_pipe_adder;

    localparam int W = 16;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, cin, out_valid, out_ready, cout;
    logic [W-1:0] a, b, sum;

    logic h_in_valid, h_in_ready, h_a, h_b, h_out_valid, h_sum, h_cout;

    always #5 clk = ~clk;

    pipe_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    pipe_adder #(.WIDTH(1), .STAGES(1)) dut_ha (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (h_in_valid),
        .in_ready  (h_in_ready),
        .a         (h_a),
        .b         (h_b),
        .cin       (1'b0),
        .out_valid (h_out_valid),
        .out_ready (1'b1),
        .sum       (h_sum),
        .cout      (h_cout)
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        int           cyc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   n_acc  = 0;
    int   n_out  = 0;
    bit   lat_check = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called at the negedge: a beat presented now is taken on the next edge.
    task automatic try_push();
        logic [W:0] t;
        if (rst_n && in_valid && in_ready) begin
            t = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            q.push_back('{sum: t[W-1:0], cout: t[W], cyc: cyc});
            n_acc++;
            $display("issue  a=0x%04h b=0x%04h cin=%0d -> expect sum=0x%04h cout=%0d", a, b, cin, t[W-1:0], t[W]);
        end
    endtask

    task automatic step(input logic v, input logic [W-1:0] av, input logic [W-1:0] bv, input logic c);
        in_valid = v;
        a        = av;
        b        = bv;
        cin      = c;
        @(negedge clk);
        try_push();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 40 && q.size() != 0; i++) begin
            @(negedge clk);
            @(posedge clk);
            #1;
        end
        check("drain_empty", q.size(), 0);
    endtask

    // Monitor: pops the scoreboard whenever a result is consumed.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_out++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_result: got sum=0x%04h with no pending beat, expected none", sum);
            end else begin
                mon_e = q.pop_front();
                $display("result sum=0x%04h cout=%0d (expect 0x%04h/%0d)", sum, cout, mon_e.sum, mon_e.cout);
                check("sum", sum, mon_e.sum);
                check("cout", cout, mon_e.cout);
                if (lat_check) check("latency", cyc - mon_e.cyc, S);
            end
        end
    end

    logic [W-1:0] snap_sum;
    logic         snap_cout;
    logic [W-1:0] t3_a   [4] = '{16'h7FFF, 16'h1234, 16'h00FF, 16'hFFFF};
    logic [W-1:0] t3_b   [4] = '{16'h8000, 16'h4321, 16'h0001, 16'hFFFF};
    logic         t3_c   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [1:0]   ha_exp;

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b1;
        out_ready  = 1'b1;
        a          = W'($urandom);
        b          = W'($urandom);
        cin        = 1'($urandom);
        h_in_valid = 1'b0;
        h_a        = 1'b0;
        h_b        = 1'b0;

        // Reset held with live input traffic: outputs must stay cleared.
        repeat (4) begin
            @(negedge clk);
            check("rst_out_valid", out_valid, 0);
            check("rst_sum", sum, 0);
            check("rst_cout", cout, 0);
            @(posedge clk);
            #1;
            a   = W'($urandom);
            b   = W'($urandom);
            cin = 1'($urandom);
        end
        #2;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Full carry ripple across every chunk, exact latency.
        lat_check = 1'b1;
        step(1'b1, 16'hFFFF, 16'h0001, 1'b0);
        drain();

        // Four back-to-back beats with carry-in, consecutive results.
        for (int i = 0; i < 4; i++) step(1'b1, t3_a[i], t3_b[i], t3_c[i]);
        drain();
        lat_check = 1'b0;

        // Back-pressure: fill, stall three cycles, then drain.
        for (int i = 0; i < 6; i++) step(1'b1, W'($urandom), W'($urandom), 1'($urandom));
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a         = W'($urandom);
        b         = W'($urandom);
        cin       = 1'($urandom);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            try_push();
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            if (i == 0) begin
                snap_sum  = sum;
                snap_cout = cout;
            end else begin
                check("bp_hold_sum", sum, snap_sum);
                check("bp_hold_cout", cout, snap_cout);
            end
            @(posedge clk);
            #1;
        end
        drain();
        check("bp_count", n_out, n_acc);

        // Random traffic with random back-pressure.
        for (int i = 0; i < 60; i++) begin
            out_ready = ($urandom_range(0, 9) < 6);
            step(($urandom_range(0, 9) < 7), W'($urandom), W'($urandom), 1'($urandom));
        end
        drain();
        check("rand_count", n_out, n_acc);

        // Reset mid-operation: in-flight beats vanish.
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) step(1'b1, W'($urandom), W'($urandom), 1'($urandom));
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_sum", sum, 0);
        check("midrst_cout", cout, 0);
        q.delete();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("midrst_quiet", out_valid, 0);
            @(posedge clk);
            #1;
        end
        check("midrst_in_ready", in_ready, 1);

        // Half-adder equivalence on the 1-bit / 1-stage instance.
        for (int i = 0; i < 4; i++) begin
            h_a        = 1'(i >> 1);
            h_b        = 1'(i);
            h_in_valid = 1'b1;
            @(negedge clk);
            check("ha_in_ready", h_in_ready, 1);
            @(posedge clk);
            #1;
            h_in_valid = 1'b0;
            ha_exp     = {1'b0, h_a} + {1'b0, h_b};
            @(negedge clk);
            $display("half   a=%0d b=%0d -> cout,sum=%0d%0d (expect %0d%0d)", h_a, h_b, h_cout, h_sum, ha_exp[1], ha_exp[0]);
            check("ha_valid", h_out_valid, 1);
            check("ha_result", {h_cout, h_sum}, ha_exp);
            @(posedge clk);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no completion, expected finish within 100000 time units");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipe_adder.md
Name: pipe_adder

Overview:
- Parametrised, pipelined successor to the team's single-bit half adder.
- Adds two WIDTH-bit operands plus a carry-in across STAGES register stages. Each stage resolves one CHUNK = WIDTH/STAGES bit slice.
- Has a valid/ready handshake so it can sit between streaming datapath blocks.
- With WIDTH=1, STAGES=1 and cin tied 0, it reproduces the half-adder truth table, registered by one cycle.

Parameters:
WIDTH, 16, operand and sum width in bits; must be >= 1.
STAGES, 4, number of pipeline stages; must be >= 1 and must divide WIDTH exactly. Violation is an elaboration error.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand beat present
in_ready  output  1  block accepts a beat this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in
out_valid  output  1  result beat present
out_ready  input  1  downstream accepts result this cycle
sum  output  WIDTH  (a+b+cin) mod 2^WIDTH
cout  output  1  bit WIDTH of a+b+cin

Behaviour:
- Reset:
  - rst_n low asynchronously clears every stage valid bit and all data registers.
  - While reset is asserted: out_valid=0, sum=0, cout=0.
  - in_ready=1 from the first edge after release.
- Reset mid-operation: all in-flight beats are discarded. No stale result emerges after release.
- Pipeline advance:
  - advance = !out_valid || out_ready.
  - in_ready = advance, a combinational function of out_valid and out_ready only; it has no dependence on in_valid.
  - When advance=1, every stage shifts one position on the clock edge.
  - When advance=0, every register holds, including sum/cout/out_valid.
- Beat acceptance: a beat is accepted when in_valid && in_ready. Stage 0 captures in_valid as its valid bit, so bubbles propagate as invalid slots.
- Stage k (0..STAGES-1) datapath:
  - Adds chunk k of a and b, bits [k*CHUNK +: CHUNK], with the carry registered from stage k-1. Stage 0 uses cin.
  - Registers the CHUNK-bit partial sum and the carry-out.
  - Carries along the already-resolved lower sum bits and the still-unprocessed upper operand chunks.
- Outputs:
  - The final stage register drives sum, cout and out_valid directly, with no output logic after the flops.
- Latency and throughput:
  - Latency is exactly STAGES cycles from acceptance to out_valid when out_ready stays high.
  - Throughput is one beat per cycle.
  - Results appear in acceptance order.
- Hold under back-pressure: while out_valid=1 and out_ready=0, sum and cout stay stable.
- Handshake rules:
  - A result is consumed when out_valid && out_ready.
  - Each accepted beat produces exactly one result: none lost, none duplicated.
- Invalid slots: sum/cout are don't-care when out_valid=0, except during and immediately after reset, when they are 0.
- Arithmetic: operands are unsigned. The carry chain within a chunk is combinational; between chunks it is registered. Overflow wraps the sum, with cout=1.
- Simultaneous accept and emit: accepting a new beat in the same cycle the final beat is consumed is legal; the pipe stays full.
- STAGES=1: single registered adder with latency 1.
- STAGES=WIDTH: bit-serial ripple with one full adder per stage.

Decomposition:
- Shared package pipe_adder_pkg holds:
  - default WIDTH and STAGES constants;
  - a chunk-width function, WIDTH/STAGES;
  - a stage-record typedef of {valid, carry, lo_sum, hi_a, hi_b}, sized from the package constants.
- One natural sub-module: adder_chunk. It is a combinational CHUNK-bit adder with cin/cout, instantiated once per stage in a generate loop.
- All registers and handshake logic live in pipe_adder.

Test Plan:
1. Reset: drive rst_n=0 with in_valid=1 and random operands -> out_valid=0, sum=0x0000, cout=0 throughout. After release, in_ready=1.
2. Full carry ripple, WIDTH=16, STAGES=4: a=0xFFFF, b=0x0001, cin=0 -> exactly 4 cycles later out_valid=1, sum=0x0000, cout=1.
3. Carry-in plus stream: four back-to-back beats, out_ready=1:
   - (0x7FFF, 0x8000, cin=1) -> 0x0000, cout=1
   - (0x1234, 0x4321, 0) -> 0x5555, cout=0
   - (0x00FF, 0x0001, 0) -> 0x0100, cout=0
   - (0xFFFF, 0xFFFF, 1) -> 0xFFFF, cout=1
   Results arrive on consecutive cycles 4..7 in this order.
4. Back-pressure:
   - Fill the pipe, then hold out_ready=0 for 3 cycles -> in_ready=0, and sum/cout/out_valid stay frozen.
   - Release -> the remaining beats drain with no loss and no duplicate. The scoreboard matches count and order.
5. Reset mid-operation: with 2 beats in flight, pulse rst_n low between clock edges -> out_valid drops immediately, and no result appears for 10 cycles after release.
6. Half-adder equivalence, WIDTH=1, STAGES=1, cin=0: inputs (0,0), (0,1), (1,0), (1,1) -> {cout,sum} = 00, 01, 01, 10, each one cycle after acceptance.
